// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the writeback queue in front of the register file.
package regfile_writeback_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t         rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Writeback FIFO: up to two pushes and one pop per cycle, with entries exposed oldest-first.
// WB_BYPASS_EN adds a per-entry data view for the bypass search.
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_a,
    input  entry_t                 push_a_entry,
    input  logic                   push_b,
    input  entry_t                 push_b_entry,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic [DEPTH-1:0]       age_valid,
    output reg_addr_t              age_rd [DEPTH]
`ifdef WB_BYPASS_EN
    ,
    output entry_t                 age_entry [DEPTH]
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    // push_b is always the younger of the pair, so it lands one slot after push_a.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    // NOTE: storage has no reset; only count and pointers decide which slots are live.
    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr] <= push_a_entry;
        if (push_b) mem[wr_ptr + PW'(1)] <= push_b_entry;
    end

    assign head = mem[rd_ptr];

    // Index k is the entry's age: k = 0 is the head, larger k is younger.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_valid[k] = CW'(k) < count;
            age_rd[k]    = mem[rd_ptr + PW'(k)].rd;
`ifdef WB_BYPASS_EN
            age_entry[k] = mem[rd_ptr + PW'(k)];
`endif
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Arbitrates ALU and load results into a small in-order writeback queue and tracks pending rd hazards.
// WB_BYPASS_EN adds bypass_hit/bypass_data outputs forwarding the youngest queued write to rs1/rs2.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int XLEN  = regfile_writeback_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       WriteData,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic [NUM_REGS-1:0]   busy_mask
`ifdef WB_BYPASS_EN
    ,
    output logic                  bypass_hit1,
    output logic                  bypass_hit2,
    output logic [XLEN-1:0]       bypass_data1,
    output logic [XLEN-1:0]       bypass_data2
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] SLOTS = (CW+1)'(DEPTH);
    localparam logic [CW:0] ONE   = (CW+1)'(1);
    localparam logic [CW:0] TWO   = (CW+1)'(2);

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          head;
    logic [CW-1:0]   count;
    logic [DEPTH-1:0] age_valid;
    reg_addr_t       age_rd [DEPTH];
    logic [CW:0]     free_slots;
    logic            pop;
    logic            ld_keep;
    logic            alu_keep;
    logic            push_a;
    logic            push_b;
    entry_t          push_a_entry;
    entry_t          push_b_entry;
`ifdef WB_BYPASS_EN
    entry_t          age_entry [DEPTH];
`endif

    // The head drains unconditionally, so its slot is already free for this edge.
    assign pop        = count != '0;
    assign free_slots = SLOTS - (CW+1)'(count) + (CW+1)'(pop);
    assign ld_ready   = reset && (free_slots >= ONE);
    assign alu_ready  = reset && ((free_slots >= TWO) || ((free_slots >= ONE) && !ld_valid));

    // Writes to x0 complete the handshake but never occupy a slot.
    assign ld_keep  = ld_valid && ld_ready && (ld_rd != '0);
    assign alu_keep = alu_valid && alu_ready && (alu_rd != '0);
    assign push_a   = ld_keep || alu_keep;
    assign push_b   = ld_keep && alu_keep;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        push_a_entry = '{rd: alu_rd, data: alu_data};
        push_b_entry = '{rd: alu_rd, data: alu_data};
        if (ld_keep) push_a_entry = '{rd: ld_rd, data: ld_data};
    end

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_a       (push_a),
        .push_a_entry (push_a_entry),
        .push_b       (push_b),
        .push_b_entry (push_b_entry),
        .pop          (pop),
        .head         (head),
        .count        (count),
        .age_valid    (age_valid),
        .age_rd       (age_rd)
`ifdef WB_BYPASS_EN
        ,
        .age_entry    (age_entry)
`endif
    );

    assign RegWrite  = pop;
    assign rd        = pop ? head.rd   : '0;
    assign WriteData = pop ? head.data : '0;

    always_comb begin
        busy_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k]) busy_mask |= reg_onehot(age_rd[k]);
        end
    end

`ifdef WB_BYPASS_EN
    // Scanning oldest to youngest lets the youngest match win.
    always_comb begin
        bypass_hit1  = 1'b0;
        bypass_hit2  = 1'b0;
        bypass_data1 = '0;
        bypass_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k] && (rs1 != '0) && (age_rd[k] == rs1)) begin
                bypass_hit1  = 1'b1;
                bypass_data1 = age_entry[k].data;
            end
            if (age_valid[k] && (rs2 != '0) && (age_rd[k] == rs2)) begin
                bypass_hit2  = 1'b1;
                bypass_data2 = age_entry[k].data;
            end
        end
    end

    assign hazard1 = (rs1 != '0) && busy_mask[rs1] && !bypass_hit1;
    assign hazard2 = (rs2 != '0) && busy_mask[rs2] && !bypass_hit2;
`else
    assign hazard1 = (rs1 != '0) && busy_mask[rs1];
    assign hazard2 = (rs2 != '0) && busy_mask[rs2];
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench: a queue-based reference model checked every cycle, plus directed literal checks.
module tb_regfile_writeback;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            alu_valid = 1'b0, ld_valid = 1'b0;
    logic [4:0]      alu_rd = '0, ld_rd = '0, rs1 = '0, rs2 = '0;
    logic [XLEN-1:0] alu_data = '0, ld_data = '0;
    logic            alu_ready, ld_ready, RegWrite, hazard1, hazard2;
    logic [4:0]      rd;
    logic [XLEN-1:0] WriteData;
    logic [31:0]     busy_mask;
`ifdef WB_BYPASS_EN
    logic            bypass_hit1, bypass_hit2;
    logic [XLEN-1:0] bypass_data1, bypass_data2;
`endif

    always #5 clk = ~clk;

    regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .RegWrite  (RegWrite),
        .rd        (rd),
        .WriteData (WriteData),
        .rs1       (rs1),
        .rs2       (rs2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .busy_mask (busy_mask)
`ifdef WB_BYPASS_EN
        ,
        .bypass_hit1  (bypass_hit1),
        .bypass_hit2  (bypass_hit2),
        .bypass_data1 (bypass_data1),
        .bypass_data2 (bypass_data2)
`endif
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_ld_ready, exp_alu_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Youngest queued write to r, as seen by a reader of the register file.
    task automatic youngest(input logic [4:0] r, output logic hit, output logic [XLEN-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (r != 0) begin
            foreach (q[i]) if (q[i].rd == r) begin hit = 1'b1; d = q[i].data; end
        end
    endtask

    // Compare every output against the model at the falling edge.
    task automatic sample();
        int          free;
        logic [31:0] busy;
        logic        h1, h2;
        logic [XLEN-1:0] d1, d2;
        @(negedge clk);
        if (!reset) q.delete();
        free = DEPTH - q.size() + ((q.size() > 0) ? 1 : 0);
        exp_ld_ready  = reset && (free >= 1);
        exp_alu_ready = reset && (free >= 2 || (free >= 1 && !ld_valid));
        busy = '0;
        foreach (q[i]) busy[q[i].rd] = 1'b1;
        youngest(rs1, h1, d1);
        youngest(rs2, h2, d2);
        check("RegWrite", RegWrite, q.size() > 0);
        check("rd", rd, (q.size() > 0) ? q[0].rd : 5'd0);
        check("WriteData", WriteData, (q.size() > 0) ? q[0].data : '0);
        check("ld_ready", ld_ready, exp_ld_ready);
        check("alu_ready", alu_ready, exp_alu_ready);
        check("busy_mask", busy_mask, busy);
`ifdef WB_BYPASS_EN
        check("bypass_hit1", bypass_hit1, h1);
        check("bypass_hit2", bypass_hit2, h2);
        check("bypass_data1", bypass_data1, d1);
        check("bypass_data2", bypass_data2, d2);
        check("hazard1", hazard1, 1'b0);
        check("hazard2", hazard2, 1'b0);
`else
        check("hazard1", hazard1, h1);
        check("hazard2", hazard2, h2);
`endif
    endtask

    // Apply the rising edge to the model, then move inputs off the edge.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            if (q.size() > 0) void'(q.pop_front());
            if (ld_valid && exp_ld_ready && ld_rd != 0) q.push_back('{rd: ld_rd, data: ld_data});
            if (alu_valid && exp_alu_ready && alu_rd != 0) q.push_back('{rd: alu_rd, data: alu_data});
        end
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic offer(input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ldat,
                         input logic av, input logic [4:0] ar, input logic [XLEN-1:0] adat);
        ld_valid = lv; ld_rd = lr; ld_data = ldat;
        alu_valid = av; alu_rd = ar; alu_data = adat;
    endtask

    initial begin
        // Reset held: every output low, readies included.
        sample();
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_alu_ready", alu_ready, 1'b0);
        check("rst_busy", busy_mask, 32'h0);
        advance();
        reset = 1'b1;
        sample();
        check("post_rst_ld_ready", ld_ready, 1'b1);
        check("post_rst_alu_ready", alu_ready, 1'b1);
        advance();

        // Single ALU result: one-cycle latency, busy for exactly that cycle.
        offer(1'b0, 5'd0, '0, 1'b1, 5'd5, 64'hDEAD);
        sample(); advance(); idle();
        sample();
        check("single_we", RegWrite, 1'b1);
        check("single_rd", rd, 5'd5);
        check("single_data", WriteData, 64'hDEAD);
        check("single_busy", busy_mask, 32'h20);
        advance();
        sample();
        check("single_we_done", RegWrite, 1'b0);
        check("single_busy_done", busy_mask, 32'h0);
        advance();

        // Simultaneous offers: load first, then ALU.
        offer(1'b1, 5'd3, 64'd1, 1'b1, 5'd4, 64'd2);
        sample();
        check("dual_alu_ready", alu_ready, 1'b1);
        advance(); idle();
        sample();
        check("dual_first_rd", rd, 5'd3);
        check("dual_first_data", WriteData, 64'd1);
        advance();
        sample();
        check("dual_second_rd", rd, 5'd4);
        check("dual_second_data", WriteData, 64'd2);
        advance();

        // x0 write is accepted and dropped.
        offer(1'b0, 5'd0, '0, 1'b1, 5'd0, 64'hFF);
        sample();
        check("x0_alu_ready", alu_ready, 1'b1);
        advance(); idle();
        sample();
        check("x0_we", RegWrite, 1'b0);
        check("x0_busy", busy_mask, 32'h0);
        advance();

        // Hazard on a queued rd=7.
        offer(1'b0, 5'd0, '0, 1'b1, 5'd7, 64'h77);
        rs1 = 5'd7; rs2 = 5'd0;
        sample(); advance(); idle();
        sample();
`ifdef WB_BYPASS_EN
        check("hz_hazard1", hazard1, 1'b0);
        check("hz_bypass_hit1", bypass_hit1, 1'b1);
        check("hz_bypass_data1", bypass_data1, 64'h77);
`else
        check("hz_hazard1", hazard1, 1'b1);
`endif
        check("hz_hazard2", hazard2, 1'b0);
        advance();

        // Continuous dual offers: full after three edges, then one load per cycle.
        for (int c = 0; c < 8; c++) begin
            offer(1'b1, 5'(8 + c), 64'(100 + c), 1'b1, 5'(16 + c), 64'(200 + c));
            sample();
            if (c >= 3) begin
                check("full_ld_ready", ld_ready, 1'b1);
                check("full_alu_ready", alu_ready, 1'b0);
            end
            advance();
        end
        idle();
        for (int c = 0; c < 6; c++) begin sample(); advance(); end

        // Reset mid-drain with three entries queued.
        offer(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
        sample(); advance();
        offer(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
        sample(); advance(); idle();
        sample();
        check("pre_rst_we", RegWrite, 1'b1);
        advance();
        reset = 1'b0;
        sample();
        check("mid_rst_we", RegWrite, 1'b0);
        advance();
        reset = 1'b1;
        sample();
        check("after_rst_we", RegWrite, 1'b0);
        check("after_rst_ld_ready", ld_ready, 1'b1);
        check("after_rst_alu_ready", alu_ready, 1'b1);
        check("after_rst_busy", busy_mask, 32'h0);
        advance();

        // Randomised traffic with a narrow rd range to force repeats, plus rare resets.
        for (int c = 0; c < 800; c++) begin
            ld_valid  = $urandom_range(0, 99) < 60;
            alu_valid = $urandom_range(0, 99) < 70;
            ld_rd     = 5'($urandom_range(0, 7));
            alu_rd    = 5'($urandom_range(0, 7));
            ld_data   = {$urandom, $urandom};
            alu_data  = {$urandom, $urandom};
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 31));
            reset     = $urandom_range(0, 99) != 0;
            sample();
            advance();
        end
        reset = 1'b1;
        idle();
        for (int c = 0; c < DEPTH + 2; c++) begin sample(); advance(); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL have a parameter XLEN, default 64, giving the data width of every result and write-port data bus.
REQ-002 The block SHALL have a parameter DEPTH, default 4, giving the number of write-queue entries; legal values are powers of two, 2..16.
REQ-003 clk  input  1  sole clock; all state SHALL change on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 alu_valid/alu_rd/alu_data  input  1/5/XLEN  ALU result offer; alu_ready  output  1  accept.
REQ-006 ld_valid/ld_rd/ld_data  input  1/5/XLEN  load result offer; ld_ready  output  1  accept.
REQ-007 RegWrite/rd/WriteData  output  1/5/XLEN  register-file write port (initiator side).
REQ-008 rs1, rs2  input  5/5  register-file read addresses from decode.
REQ-009 hazard1, hazard2  output  1/1  a write to rs1/rs2 is still queued.
REQ-010 busy_mask  output  32  bit i set while any queued entry targets xi.

Function
REQ-011 A transfer SHALL occur on a source when valid and ready are both high at a rising edge; ready SHALL NOT depend on that source's own valid.
REQ-012 Queue: DEPTH-entry FIFO in arrival order with a count held in $clog2(DEPTH)+1 bits; pointers SHALL wrap modulo DEPTH.
REQ-013 ld_ready SHALL be high when free slots >= 1; alu_ready SHALL be high when free slots >= 2, or free slots >= 1 and ld_valid is low.
REQ-014 Simultaneous accept SHALL enqueue the load entry ahead of the ALU entry.
REQ-015 A transfer with rd == 0 SHALL be accepted and discarded: no enqueue, no busy bit, no write.
REQ-016 Drain: when the queue is non-empty, RegWrite SHALL be high with rd/WriteData equal to the head entry, and the head SHALL pop at that edge, one entry per cycle.
REQ-017 Latency: an entry accepted at edge N into an empty queue SHALL appear on the write port during cycle N+1.
REQ-018 Free slots for REQ-013 SHALL count the slot freed by the pop in the same cycle, so a full queue accepts one entry while draining.
REQ-019 When the queue is empty, RegWrite SHALL be 0 and rd/WriteData SHALL be 0.
REQ-020 busy_mask SHALL be the OR of the one-hot decode of rd over all valid entries, registered-state based with no combinational path from the inputs.
REQ-021 hazardN SHALL equal busy_mask[rsN], and SHALL be 0 when rsN == 0.
REQ-022 Two queued writes to the same rd SHALL both be issued, in order; busy SHALL clear only after the last one pops.

Reset
REQ-023 While reset is low the block SHALL clear count and both pointers and hold every output at 0, including alu_ready, ld_ready and busy_mask.
REQ-024 Reset asserted mid-drain SHALL drop all queued entries with no further RegWrite pulse; queue storage contents need not be cleared.
REQ-025 In the first cycle after reset rises, ready SHALL follow REQ-013 with the queue empty.

Configuration
REQ-026 Macro WB_BYPASS_EN defined: the block SHALL add outputs bypass_hit1/2 (1) and bypass_data1/2 (XLEN), giving the data of the youngest queued entry matching rsN.
REQ-027 With WB_BYPASS_EN defined and a match present, hazardN SHALL be 0.
REQ-028 WB_BYPASS_EN undefined: the bypass ports and logic SHALL be absent and hazards SHALL follow REQ-021.

Structure
REQ-029 A shared package SHALL hold XLEN, REG_ADDR_W = 5, NUM_REGS = 32 and a wb_entry_t struct {rd, data}.
REQ-030 The FIFO SHALL be a sub-module wb_fifo (parameters DEPTH, entry type) exposing push/pop, count and per-entry valid/rd.

Verification
REQ-031 Single ALU result: alu rd=5, data=0xDEAD at edge 0 -> RegWrite=1, rd=5, WriteData=0xDEAD in cycle 1; busy_mask[5] set during cycle 1 only.
REQ-032 Simultaneous offers with the queue empty: ld rd=3 data=1 and alu rd=4 data=2 -> both accepted; writes issued x3 then x4 in consecutive cycles.
REQ-033 Fill with DEPTH=4 and the drain blocked by continuous offers -> at most one entry accepted per cycle once full, count never above 4, no entry lost or reordered.
REQ-034 x0 discard: alu rd=0 data=0xFF -> accepted, RegWrite stays 0, busy_mask stays 0.
REQ-035 Hazard: queue holds rd=7, rs1=7, rs2=0 -> hazard1=1, hazard2=0; with WB_BYPASS_EN -> hazard1=0, bypass_hit1=1, bypass_data1 = queued data.
REQ-036 Reset mid-drain: 3 entries queued, reset low for 1 cycle -> no further RegWrite pulses, count=0, both readies high after release.
